// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants one of two ports per cycle onto a single-port RAM and returns tagged read data.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 1 has fixed priority.
module ram_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_regce,
  input  logic [DATA_W-1:0] ram_dout
);
  logic w_sel1, w_gnt0, w_gnt1, w_rd;
  logic [1:0] w_tag_in, w_tag_out;
  logic r_rv0, r_rv1;
  logic [DATA_W-1:0] r_rd0, r_rd1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_last;
  // r_last=1 means port 1 was granted last, so port 0 wins the next conflict
  assign w_sel1 = p1_req & (~p0_req | ~r_last);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last <= 1'b1;
    else if (w_gnt0 | w_gnt1) r_last <= w_gnt1;
`else
  assign w_sel1 = p1_req;
`endif
  assign w_gnt1    = ~rst & w_sel1;
  assign w_gnt0    = ~rst & p0_req & ~w_sel1;
  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;
  assign ram_addr  = w_gnt1 ? p1_addr : p0_addr;
  assign ram_din   = w_gnt1 ? p1_wdata : p0_wdata;
  assign ram_we    = w_gnt1 ? p1_we : w_gnt0 & p0_we;
  assign ram_regce = ~rst;
  assign w_rd      = w_gnt1 ? ~p1_we : w_gnt0 & ~p0_we;
  assign w_tag_in  = {w_rd, w_gnt1};
  // tag = {valid, port}; the output register below is the last pipeline stage
  generate
    if (RD_LATENCY == 0) begin : g_l0
      assign w_tag_out = w_tag_in;
    end else begin : g_ln
      logic [1:0] r_tag [RD_LATENCY];
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
        end else begin
          r_tag[0] <= w_tag_in;
          for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
      assign w_tag_out = r_tag[RD_LATENCY-1];
    end
  endgenerate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_rv0 <= w_tag_out[1] & ~w_tag_out[0];
      r_rv1 <= w_tag_out[1] & w_tag_out[0];
      if (w_tag_out[1] & ~w_tag_out[0]) r_rd0 <= ram_dout;
      if (w_tag_out[1] & w_tag_out[0]) r_rd1 <= ram_dout;
    end
  assign p0_rvalid = r_rv0;
  assign p1_rvalid = r_rv1;
  assign p0_rdata  = r_rd0;
  assign p1_rdata  = r_rd1;
endmodule
